// File: rtl/apb_uart_regfile.sv
// APB slave register file for a UART: BAUD/CTRL/DATA/STATUS plus scratch registers,
// with configurable wait states and one-cycle TX push / RX pop pulses.
module apb_uart_regfile #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 3,
  parameter int          WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] BAUD_RST = 'h03
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] baud_div,
  output logic              tx_en,
  output logic              rx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_rd,
  input  logic              tx_rdy,
  input  logic              rx_rdy,
  output logic              irq
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [3:0]        WS     = 4'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] A_BAUD = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   regs [NREG];
  logic                tx_rdy_q, rx_rdy_q, ovr;
  logic                done, do_wr, tx_push, rx_pop, ovr_set, ovr_clr;
  logic [DATA_W-1:0]   status;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETUP) begin
        cnt     <= WS;
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (psel && !penable) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        // Abort is only honoured while wait states remain; completion always finishes.
        if (cnt == '0)             state_nxt = (psel && !penable) ? SETUP : IDLE;
        else if (!psel || !penable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done   = (state == ACCESS) && (cnt == '0);
  assign status = {{(DATA_W-3){1'b0}}, ovr, rx_rdy_q, tx_rdy_q};

  always_comb begin
    pready  = done;
    pslverr = 1'b0;
    prdata  = '0;
    do_wr   = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    ovr_set = 1'b0;
    ovr_clr = 1'b0;
    if (done) begin
      if (write_q) begin
        if (addr_q == A_STAT) begin
          pslverr = 1'b1;
        end else if (addr_q == A_DATA) begin
          if (tx_rdy_q) tx_push = 1'b1;
          else begin
            pslverr = 1'b1;
            ovr_set = 1'b1;
          end
        end else begin
          do_wr = 1'b1;
        end
      end else begin
        if (addr_q == A_STAT) begin
          prdata  = status;
          ovr_clr = 1'b1;
        end else if (addr_q == A_DATA) begin
          if (rx_rdy_q) begin
            prdata = rx_data;
            rx_pop = 1'b1;
          end else begin
            pslverr = 1'b1;
          end
        end else begin
          prdata = regs[addr_q];
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i[ADDR_W-1:0]] <= '0;
      regs[A_BAUD] <= BAUD_RST;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
      rx_rd    <= 1'b0;
      ovr      <= 1'b0;
      tx_rdy_q <= 1'b0;
      rx_rdy_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      tx_rdy_q <= tx_rdy;
      rx_rdy_q <= rx_rdy;
      tx_wr    <= tx_push;
      rx_rd    <= rx_pop;
      if (do_wr)   regs[addr_q] <= wdata_q;
      if (tx_push) tx_data      <= wdata_q;
      // Set is evaluated last so a coincident overrun survives a STATUS-read clear.
      if (ovr_clr) ovr <= 1'b0;
      if (ovr_set) ovr <= 1'b1;
      irq <= (regs[A_CTRL][2] & rx_rdy_q) | (regs[A_CTRL][3] & tx_rdy_q) | ovr;
    end
  end

  assign baud_div = regs[A_BAUD];
  assign tx_en    = regs[A_CTRL][0];
  assign rx_en    = regs[A_CTRL][1];

endmodule

// File: tb/tb_apb_uart_regfile.sv
// Bench for apb_uart_regfile: directed scenarios plus random transfers checked
// against a register-map model; one zero-wait and one three-wait instance.
module tb_apb_uart_regfile;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel0 = 1'b0, penable0 = 1'b0, psel3 = 1'b0, penable3 = 1'b0;
  logic       pwrite = 1'b0;
  logic [2:0] paddr = '0;
  logic [7:0] pwdata = '0, rx_data = '0;
  logic       tx_rdy = 1'b0, rx_rdy = 1'b0;

  logic [7:0] prdata0, baud_div0, tx_data0, prdata3, baud_div3, tx_data3;
  logic       pready0, pslverr0, tx_en0, rx_en0, tx_wr0, rx_rd0, irq0;
  logic       pready3, pslverr3, tx_en3, rx_en3, tx_wr3, rx_rd3, irq3;

  always #5 pclk = ~pclk;

  apb_uart_regfile #(.DATA_W(8), .ADDR_W(3), .WAIT_STATES(0), .BAUD_RST(8'h03)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable0), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .baud_div(baud_div0), .tx_en(tx_en0), .rx_en(rx_en0), .tx_data(tx_data0), .tx_wr(tx_wr0),
    .rx_data(rx_data), .rx_rd(rx_rd0), .tx_rdy(tx_rdy), .rx_rdy(rx_rdy), .irq(irq0));

  apb_uart_regfile #(.DATA_W(8), .ADDR_W(3), .WAIT_STATES(3), .BAUD_RST(8'h03)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable3), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .baud_div(baud_div3), .tx_en(tx_en3), .rx_en(rx_en3), .tx_data(tx_data3), .tx_wr(tx_wr3),
    .rx_data(rx_data), .rx_rd(rx_rd3), .tx_rdy(tx_rdy), .rx_rdy(rx_rdy), .irq(irq3));

  int passes = 0, fails = 0, total = 0;
  int txw_cnt = 0, rxr_cnt = 0;

  // Reference model of the zero-wait instance's register map
  logic [7:0] m_regs [8];
  logic [7:0] m_txd;
  logic       m_ov;

  always @(negedge pclk) begin
    if (tx_wr0 === 1'b1) txw_cnt++;
    if (rx_rd0 === 1'b1) rxr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_regs[0] = 8'h03;
    m_txd = 8'h00;
    m_ov  = 1'b0;
  endtask

  function automatic logic m_irq();
    return (m_regs[1][2] & rx_rdy) | (m_regs[1][3] & tx_rdy) | m_ov;
  endfunction

  // Called just after a rising edge; returns just after the edge ending completion.
  task automatic apb(input bit on3, input bit wr, input logic [2:0] a, input logic [7:0] wd,
                     input bit keep, output logic [7:0] rd, output logic err,
                     output int lows, output bit ok);
    paddr = a; pwrite = wr; pwdata = wd;
    if (on3) begin psel3 = 1'b1; penable3 = 1'b0; end
    else     begin psel0 = 1'b1; penable0 = 1'b0; end
    @(posedge pclk); #1;
    if (on3) penable3 = 1'b1; else penable0 = 1'b1;
    lows = 0; ok = 1'b0; rd = 'x; err = 1'bx;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge pclk);
      if ((on3 ? pready3 : pready0) === 1'b1) begin
        ok  = 1'b1;
        rd  = on3 ? prdata3 : prdata0;
        err = on3 ? pslverr3 : pslverr0;
      end else begin
        lows++;
      end
    end
    @(posedge pclk); #1;
    if (on3) begin penable3 = 1'b0; psel3 = keep; end
    else     begin penable0 = 1'b0; psel0 = keep; end
  endtask

  task automatic xfer0(input bit wr, input logic [2:0] a, input logic [7:0] wd, input bit keep);
    logic [7:0] e_rd, rd;
    logic       e_err, err;
    bit         e_tx, e_rx, ok;
    int         lows, t0, r0;
    e_rd = 8'h00; e_err = 1'b0; e_tx = 1'b0; e_rx = 1'b0;
    if (wr) begin
      if (a == 3'd3) e_err = 1'b1;
      else if (a == 3'd2) begin
        if (tx_rdy) begin e_tx = 1'b1; m_txd = wd; end
        else begin e_err = 1'b1; m_ov = 1'b1; end
      end else m_regs[a] = wd;
    end else begin
      if (a == 3'd3) begin e_rd = {5'b0, m_ov, rx_rdy, tx_rdy}; m_ov = 1'b0; end
      else if (a == 3'd2) begin
        if (rx_rdy) begin e_rd = rx_data; e_rx = 1'b1; end
        else e_err = 1'b1;
      end else e_rd = m_regs[a];
    end
    t0 = txw_cnt; r0 = rxr_cnt;
    apb(1'b0, wr, a, wd, keep, rd, err, lows, ok);
    check("xfer_complete", 32'(ok), 1);
    check("pready_low_cycles", lows, 1);
    check("prdata", rd, e_rd);
    check("pslverr", err, e_err);
    check("tx_wr_pulse", tx_wr0, e_tx);
    check("rx_rd_pulse", rx_rd0, e_rx);
    check("pready_after", pready0, 0);
    check("baud_div", baud_div0, m_regs[0]);
    check("tx_rx_en", {rx_en0, tx_en0}, m_regs[1][1:0]);
    check("tx_data", tx_data0, m_txd);
    if (!keep) begin
      check("prdata_idle", prdata0, 0);
      @(posedge pclk); #1;
      check("tx_wr_single", txw_cnt - t0, 32'(e_tx));
      check("rx_rd_single", rxr_cnt - r0, 32'(e_rx));
      check("irq", irq0, m_irq());
    end
  endtask

  logic [7:0] rd3;
  logic       err3;
  int         lows3, t_save;
  bit         ok3;

  initial begin
    model_reset();
    #12;
    check("rst_pready", pready0, 0);
    check("rst_prdata", prdata0, 0);
    check("rst_pslverr", pslverr0, 0);
    check("rst_baud", baud_div0, 8'h03);
    check("rst_txrx", {tx_wr0, rx_rd0, irq0, tx_en0, rx_en0}, 0);
    check("rst_tx_data", tx_data0, 0);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    // Baud write/readback
    xfer0(1'b1, 3'd0, 8'h1A, 1'b0);
    check("baud_1a", baud_div0, 8'h1A);
    xfer0(1'b0, 3'd0, 8'h00, 1'b0);

    // TX push, then overrun
    tx_rdy = 1'b1;
    xfer0(1'b1, 3'd2, 8'h55, 1'b0);
    check("tx_data_55", tx_data0, 8'h55);
    tx_rdy = 1'b0;
    xfer0(1'b1, 3'd2, 8'h66, 1'b0);
    check("irq_overrun", irq0, 1);
    xfer0(1'b0, 3'd3, 8'h00, 1'b0);

    // RX interrupt and pop
    xfer0(1'b1, 3'd1, 8'h06, 1'b0);
    rx_rdy = 1'b1; rx_data = 8'hA5;
    repeat (2) @(posedge pclk); #1;
    check("irq_rx_before_read", irq0, 1);
    xfer0(1'b0, 3'd2, 8'h00, 1'b0);
    rx_rdy = 1'b0;
    repeat (2) @(posedge pclk); #1;
    xfer0(1'b0, 3'd2, 8'h00, 1'b0);

    // Back-to-back with psel held; STATUS write must not disturb overrun
    xfer0(1'b1, 3'd2, 8'h11, 1'b1);
    xfer0(1'b1, 3'd3, 8'hFF, 1'b1);
    xfer0(1'b0, 3'd3, 8'h00, 1'b0);

    // Three-wait instance: latency and abort
    apb(1'b1, 1'b1, 3'd1, 8'h3C, 1'b0, rd3, err3, lows3, ok3);
    check("ws3_wr_ok", 32'(ok3), 1);
    check("ws3_wr_lows", lows3, 4);
    check("ws3_wr_err", err3, 0);
    apb(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, rd3, err3, lows3, ok3);
    check("ws3_rd_lows", lows3, 4);
    check("ws3_rd_ctrl", rd3, 8'h3C);
    check("ws3_pready_after", pready3, 0);
    paddr = 3'd0; pwrite = 1'b1; pwdata = 8'h77; psel3 = 1'b1; penable3 = 1'b0;
    @(posedge pclk); #1; penable3 = 1'b1;
    repeat (2) @(posedge pclk); #1;
    check("ws3_abort_pending", pready3, 0);
    psel3 = 1'b0; penable3 = 1'b0;
    repeat (4) @(posedge pclk); #1;
    check("ws3_abort_baud", baud_div3, 8'h03);
    check("ws3_abort_pready", pready3, 0);
    apb(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, rd3, err3, lows3, ok3);
    check("ws3_abort_readback", rd3, 8'h03);

    // Random transfers against the model
    for (int n = 0; n < 80; n++) begin
      tx_rdy  = 1'($urandom_range(0, 1));
      rx_rdy  = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      xfer0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
    end

    // Reset in the completion cycle of a DATA write
    tx_rdy = 1'b1;
    xfer0(1'b1, 3'd0, 8'h5A, 1'b0);
    xfer0(1'b1, 3'd1, 8'h0F, 1'b0);
    paddr = 3'd2; pwrite = 1'b1; pwdata = 8'h99; psel0 = 1'b1; penable0 = 1'b0;
    @(posedge pclk); #1; penable0 = 1'b1;
    @(posedge pclk); #1;
    check("rst_mid_access", pready0, 1);
    t_save = txw_cnt;
    presetn = 1'b0; #1;
    check("rst_mid_pready", pready0, 0);
    check("rst_mid_irq", irq0, 0);
    psel0 = 1'b0; penable0 = 1'b0;
    model_reset();
    @(negedge pclk); presetn = 1'b1;
    repeat (2) @(posedge pclk); #1;
    check("rst_mid_no_tx_wr", txw_cnt - t_save, 0);
    check("rst_mid_baud", baud_div0, 8'h03);
    check("rst_mid_ctrl_en", {rx_en0, tx_en0}, 0);
    check("rst_mid_tx_data", tx_data0, 0);
    xfer0(1'b0, 3'd1, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
